// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver, 3-sample majority per bit, parity and framing checks.
// Define UART_RX_BREAK_DET_EN to add break_flag for all-zero frames.
module uart_rx_param #(
  parameter int CLK_PER_BIT = 56,
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              rs232_rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              po_flag,
  output logic              parity_err,
  output logic              frame_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic              break_flag,
`endif
  output logic              busy
);
  localparam int MID = CLK_PER_BIT / 2;
  localparam int CW  = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] S0 = CW'(MID - 1), S1 = CW'(MID), S2 = CW'(MID + 1), LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [3:0] DLAST = 4'(DATA_W - 1), SLAST = 4'(STOP_BITS - 1);

  if (CLK_PER_BIT < 8 || DATA_W < 5 || DATA_W > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $fatal(1, "uart_rx_param: unsupported parameter values");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q, prev_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              s0_q, s1_q, maj, res, wrap, fall;
  logic              perr_q, perr_d, ferr_q, ferr_d, po_d;

  assign fall = prev_q & ~sync2_q;
  assign wrap = cnt_q == LAST;
  assign res  = cnt_q == S2;
  assign maj  = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
  assign busy = state_q != IDLE;

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || wrap) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    po_d    = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        bit_d   = '0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
      end
      START: state_d = (res && maj) ? IDLE : wrap ? DATA : START;
      DATA: begin
        if (res) shift_d = {maj, shift_q[DATA_W-1:1]};
        if (wrap) begin
          bit_d = bit_q == DLAST ? '0 : bit_q + 1'b1;
          if (bit_q == DLAST) state_d = PARITY_MODE != 0 ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (res) perr_d = ^shift_q ^ maj ^ (PARITY_MODE == 1);
        if (wrap) state_d = STOP;
      end
      STOP: begin
        if (res) ferr_d = ferr_q | ~maj;
        // leave at mid of the final stop bit so a back-to-back start edge is never missed
        if (res && bit_q == SLAST) begin
          po_d    = 1'b1;
          state_d = IDLE;
        end
        if (wrap) bit_d = bit_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) cnt_d = '0;
  end

  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      {sync1_q, sync2_q, prev_q} <= 3'b111;
      {s0_q, s1_q}               <= 2'b00;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rx_data    <= '0;
      po_flag    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1_q <= rs232_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      s0_q    <= cnt_q == S0 ? sync2_q : s0_q;
      s1_q    <= cnt_q == S1 ? sync2_q : s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      po_flag <= po_d;
      if (po_d) begin
        rx_data    <= shift_q;
        parity_err <= perr_q;
        frame_err  <= ferr_d;
      end
    end

`ifdef UART_RX_BREAK_DET_EN
  logic zero_q;

  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      zero_q     <= 1'b0;
      break_flag <= 1'b0;
    end else begin
      if (state_q == IDLE && fall) zero_q <= 1'b1;
      else if (res && state_q != START && state_q != IDLE) zero_q <= zero_q & ~maj;
      if (po_d) break_flag <= zero_q & ~maj;
    end
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: frame-level model checks two receiver configurations with directed and random frames.
`timescale 1ns/1ps
module tb_uart_rx_param;
  localparam int CPB0 = 56, DW0 = 8, PM0 = 0, SB0 = 1;
  localparam int CPB1 = 16, DW1 = 7, PM1 = 2, SB1 = 2;
`ifdef UART_RX_BREAK_DET_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bk;
  } exp_t;

  logic sclk = 1'b0, s_rst_n = 1'b0, rx0 = 1'b1, rx1 = 1'b1;
  logic [DW0-1:0] d0;
  logic [DW1-1:0] d1;
  logic po0, po1, pe0, pe1, fe0, fe1, bz0, bz1, bk0, bk1;

  always #5 sclk = ~sclk;

  uart_rx_param #(.CLK_PER_BIT(CPB0), .DATA_W(DW0), .PARITY_MODE(PM0), .STOP_BITS(SB0)) dut0 (
    .sclk(sclk), .s_rst_n(s_rst_n), .rs232_rx(rx0), .rx_data(d0), .po_flag(po0),
    .parity_err(pe0), .frame_err(fe0),
`ifdef UART_RX_BREAK_DET_EN
    .break_flag(bk0),
`endif
    .busy(bz0));

  uart_rx_param #(.CLK_PER_BIT(CPB1), .DATA_W(DW1), .PARITY_MODE(PM1), .STOP_BITS(SB1)) dut1 (
    .sclk(sclk), .s_rst_n(s_rst_n), .rs232_rx(rx1), .rx_data(d1), .po_flag(po1),
    .parity_err(pe1), .frame_err(fe1),
`ifdef UART_RX_BREAK_DET_EN
    .break_flag(bk1),
`endif
    .busy(bz1));

`ifndef UART_RX_BREAK_DET_EN
  assign bk0 = 1'b0;
  assign bk1 = 1'b0;
`endif

  int   total = 0, bad = 0, cyc = 0, po_cyc0 = 0;
  int   npo [2];
  logic ppo [2];
  exp_t last [2];
  exp_t q0[$], q1[$];

  always @(posedge sclk) cyc++;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic cmp(input int id, input logic po, input exp_t a);
    total++;
    if (po && ppo[id]) begin
      bad++;
      $display("FAIL po_width%0d: got 2-cycle pulse required 1", id);
    end
    ppo[id] = po;
    if (po) begin
      npo[id]++;
      if (id == 0) po_cyc0 = cyc;
      if ((id == 0 ? q0.size() : q1.size()) == 0) begin
        bad++;
        $display("FAIL spurious_po%0d: got pulse data %h required none", id, a.data);
        last[id] = a;
      end else last[id] = id == 0 ? q0.pop_front() : q1.pop_front();
    end
    chk($sformatf("frame%0d", id), 16'(a), 16'(last[id]));
  endtask

  always @(negedge sclk) begin
    cmp(0, po0, {9'(d0), pe0, fe0, bk0});
    cmp(1, po1, {9'(d1), pe1, fe1, bk1});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic drive(input int id, input logic v);
    if (id == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic idle(input int id, input int n);
    drive(id, 1'b1);
    step(n);
  endtask

  // stops[0] is the first stop bit; cut > 0 sends only that many leading bits and expects nothing
  task automatic send(input int id, input logic [8:0] data_in, input logic pbit, input logic [1:0] stops,
                      input int glitch_at, input int cut);
    int cpb, dw, pm, sb, n;
    logic [8:0] data;
    logic [15:0] bits;
    exp_t e;
    cpb  = id ? CPB1 : CPB0;
    dw   = id ? DW1 : DW0;
    pm   = id ? PM1 : PM0;
    sb   = id ? SB1 : SB0;
    data = data_in & 9'((1 << dw) - 1);
    bits = '0;
    n    = 1;
    for (int i = 0; i < dw; i++) begin
      bits[n] = data[i];
      n++;
    end
    if (pm != 0) begin
      bits[n] = pbit;
      n++;
    end
    for (int i = 0; i < sb; i++) begin
      bits[n] = stops[i];
      n++;
    end
    e.data = data;
    e.pe   = pm == 0 ? 1'b0 : ((^data ^ pbit) != (pm == 1));
    e.fe   = sb == 1 ? !stops[0] : !(stops[0] && stops[1]);
    e.bk   = BRK_EN && data == 0 && (pm == 0 || !pbit) && (sb == 1 ? !stops[0] : stops == 2'b00);
    if (cut == 0) begin
      if (id == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    for (int i = 0; i < (cut != 0 ? cut : n); i++)
      for (int c = 0; c < cpb; c++) begin
        drive(id, bits[i] ^ (i * cpb + c == glitch_at));
        step(1);
      end
  endtask

  task automatic drain(input int id);
    for (int i = 0; i < 2000 && (id == 0 ? q0.size() : q1.size()) != 0; i++) step(1);
    chk($sformatf("drain%0d", id), 16'(id == 0 ? q0.size() : q1.size()), 16'd0);
    if (id == 0) q0.delete();
    else q1.delete();
  endtask

  initial begin
    int lat, n0;
    logic [1:0] st;
    last[0] = '0;
    last[1] = '0;
    npo     = '{0, 0};
    ppo     = '{1'b0, 1'b0};
    step(3);
    chk("rst_data0", 16'(d0), 16'h0);
    chk("rst_flags0", {13'd0, pe0, fe0, bz0}, 16'h0);
    chk("rst_flags1", {13'd0, pe1, fe1, bz1}, 16'h0);
    s_rst_n = 1'b1;
    step(10);

    lat = cyc;
    send(0, 9'h55, 1'b0, 2'b11, -1, 0);
    idle(0, 5);
    drain(0);
    lat = po_cyc0 - lat;
    total++;
    if (lat < 535 || lat > 537) begin
      bad++;
      $display("FAIL latency0: got %0d required 536 +-1", lat);
    end
    chk("data_55", 16'(d0), 16'h55);
    chk("err_55", {14'd0, pe0, fe0}, 16'h0);

    n0 = npo[0];
    send(0, 9'h12, 1'b0, 2'b11, -1, 0);
    send(0, 9'h34, 1'b0, 2'b11, -1, 0);
    send(0, 9'hAB, 1'b0, 2'b11, -1, 0);
    send(0, 9'hFF, 1'b0, 2'b11, -1, 0);
    idle(0, 5);
    drain(0);
    chk("b2b_count", 16'(npo[0] - n0), 16'd4);
    chk("b2b_last", 16'(d0), 16'hFF);

    send(1, 9'h0F, 1'b1, 2'b11, -1, 0);
    idle(1, 5);
    drain(1);
    chk("par_bad", {7'd0, 9'(d1)}, 16'h0F);
    chk("par_bad_pe", 16'(pe1), 16'h1);
    send(1, 9'h0F, 1'b0, 2'b11, -1, 0);
    idle(1, 5);
    drain(1);
    chk("par_ok_pe", 16'(pe1), 16'h0);

    send(0, 9'hA5, 1'b0, 2'b00, -1, 0);
    idle(0, 10);
    drain(0);
    chk("ferr_data", 16'(d0), 16'hA5);
    chk("ferr_set", 16'(fe0), 16'h1);
    send(0, 9'h3C, 1'b0, 2'b11, -1, 0);
    idle(0, 5);
    drain(0);
    chk("ferr_clr", {15'd0, fe0}, 16'h0);

    n0 = npo[0];
    drive(0, 1'b0);
    for (int c = 0; c < 36; c++) begin
      if (c == 10) drive(0, 1'b1);
      if (c == 8) chk("glitch_busy", 16'(bz0), 16'h1);
      step(1);
    end
    chk("glitch_idle", 16'(bz0), 16'h0);
    chk("glitch_nopo", 16'(npo[0] - n0), 16'd0);

    send(0, 9'h00, 1'b0, 2'b11, 4 * CPB0 + CPB0 / 2, 0);
    idle(0, 5);
    drain(0);
    chk("spike_data", {8'd0, d0}, 16'h00);

    send(0, 9'h00, 1'b0, 2'b00, -1, 0);
    idle(0, 20);
    drain(0);
    chk("break_fe", 16'(fe0), 16'h1);
    if (BRK_EN) chk("break_set", 16'(bk0), 16'h1);
    send(0, 9'h3C, 1'b0, 2'b11, -1, 0);
    idle(0, 5);
    drain(0);
    if (BRK_EN) chk("break_clr", 16'(bk0), 16'h0);

    send(0, 9'h96, 1'b0, 2'b11, -1, 5);
    step(CPB0 / 2);
    s_rst_n = 1'b0;
    rx0     = 1'b1;
    last[0] = '0;
    last[1] = '0;
    step(5);
    chk("midrst_data", 16'(d0), 16'h0);
    chk("midrst_busy", {15'd0, bz0}, 16'h0);
    s_rst_n = 1'b1;
    step(10);
    send(0, 9'hC3, 1'b0, 2'b11, -1, 0);
    idle(0, 5);
    drain(0);
    chk("after_rst", 16'(d0), 16'hC3);

    for (int k = 0; k < 30; k++) begin
      st = ($urandom % 6 == 0) ? 2'b00 : 2'b11;
      send(0, ($urandom % 8 == 0) ? 9'h0 : 9'($urandom), 1'b0, st, -1, 0);
      idle(0, st[0] ? $urandom_range(0, 10) : $urandom_range(8, 20));
    end
    drain(0);
    for (int k = 0; k < 40; k++) begin
      st = ($urandom % 3 == 0) ? 2'($urandom) : 2'b11;
      send(1, ($urandom % 8 == 0) ? 9'h0 : 9'($urandom), 1'($urandom), st, -1, 0);
      idle(1, st[1] ? $urandom_range(0, 6) : $urandom_range(8, 16));
    end
    drain(1);
    step(5);
    chk("end_busy", {14'd0, bz0, bz1}, 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
